// File: rtl/dmm_unit_responder.sv
// Heap scratchpad responder for the dmm_unit request port: 32-byte lines, byte-granular swap/read access.
// Optional wait states are enabled by defining DMM_RESP_WAIT_EN (WAIT_CYCLES then sets their count).
module dmm_unit_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h7000_0000,
    parameter int unsigned DEPTH_LINES = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dmm_unit_strobe,
    input  logic [31:0]  dmm_unit_addr,
    input  logic         dmm_unit_rw,
    input  logic [255:0] dmm_unit_dataout,
    input  logic [7:0]   dmm_unit_size,
    output logic         dmm_unit_done,
    output logic [255:0] dmm_unit_datain,
    output logic         busy,
    output logic         addr_err,
    input  logic         err_clr,
    output logic [2:0]   dbg_state
);

    localparam int unsigned LINE_W     = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam logic [31:0] HEAP_BYTES = 32'(DEPTH_LINES * 32);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_COMMIT  = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    // Handshake: a request is taken when strobe=1 at a rising edge in IDLE; done pulses
    // for exactly one cycle per accepted request and strobe is ignored until IDLE again.

    logic [2:0]   state_q, state_d;
    logic [31:0]  off_q;
    logic         rw_q;
    logic [255:0] wdata_q;
    logic [7:0]   size_q;
    logic         done_q;
    logic [255:0] datain_q;
    logic         err_q;
    logic [255:0] rd_line_q;
    logic [255:0] mem_q [DEPTH_LINES];

    logic              accept;
    logic              commit;
    logic              mem_we;
    logic [31:0]       off_in;
    logic [LINE_W-1:0] line_in;
    logic              in_range;
    logic [4:0]        b;
    logic [5:0]        size_eff;
    logic [5:0]        room;
    logic [5:0]        n;
    logic [31:0]       byte_en;
    logic [31:0]       line_en;
    logic [255:0]      rd_shift;
    logic [255:0]      wr_shift;
    logic [255:0]      rd_field;
    logic [255:0]      merged;

`ifdef DMM_RESP_WAIT_EN
    localparam int unsigned WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic              wait_done;

    assign wait_done = (wait_cnt_q == WCNT_W'(WAIT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
        end else begin
            wait_cnt_q <= '0;
        end
    end
`endif

    assign accept  = (state_q == S_IDLE) && dmm_unit_strobe;
    assign commit  = (state_q == S_COMMIT);
    assign off_in  = dmm_unit_addr - BASE_ADDR;
    assign line_in = off_in[5 +: LINE_W];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (dmm_unit_strobe) state_d = S_FETCH;
`ifdef DMM_RESP_WAIT_EN
            S_FETCH:   state_d = (WAIT_CYCLES != 0) ? S_WAIT : S_COMMIT;
            S_WAIT:    if (wait_done) state_d = S_COMMIT;
`else
            S_FETCH:   state_d = S_COMMIT;
`endif
            S_COMMIT:  state_d = S_RECOVER;
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Byte window inside the line: starts at b, length clipped so it never crosses the line end.
    assign in_range = (off_q < HEAP_BYTES);
    assign b        = off_q[4:0];
    assign size_eff = (size_q == 8'd0 || size_q > 8'd32) ? 6'd32 : size_q[5:0];
    assign room     = 6'd32 - {1'b0, b};
    assign n        = (size_eff < room) ? size_eff : room;
    assign rd_shift = rd_line_q >> {b, 3'b000};
    assign wr_shift = wdata_q << {b, 3'b000};
    assign line_en  = byte_en << b;

    always_comb begin
        byte_en  = '0;
        rd_field = '0;
        merged   = '0;
        for (int i = 0; i < 32; i++) begin
            byte_en[i] = (6'(i) < n);
        end
        for (int i = 0; i < 32; i++) begin
            rd_field[8*i +: 8] = byte_en[i] ? rd_shift[8*i +: 8] : 8'h00;
            merged[8*i +: 8]   = line_en[i] ? wr_shift[8*i +: 8] : rd_line_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            off_q    <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
            size_q   <= '0;
            done_q   <= 1'b0;
            datain_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= commit;
            if (accept) begin
                off_q   <= off_in;
                rw_q    <= dmm_unit_rw;
                wdata_q <= dmm_unit_dataout;
                size_q  <= dmm_unit_size;
            end
            if (commit) begin
                datain_q <= in_range ? rd_field : '0;
            end
            // A fresh range error outranks a simultaneous clear.
            if (commit && !in_range) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign mem_we = commit && rw_q && in_range && !rst;

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_line_q <= mem_q[line_in];
        end
        if (mem_we) begin
            mem_q[off_q[5 +: LINE_W]] <= merged;
        end
    end

    assign dmm_unit_done   = done_q;
    assign dmm_unit_datain = datain_q;
    assign addr_err        = err_q;
    assign busy            = (state_q != S_IDLE);
    assign dbg_state       = state_q;

endmodule
